cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_controller_if.sv | 38 +++
 rtl/cache_way_array.sv | 59 +++++
 rtl/cache_controller.sv | 166 ++++++++++++++++
 tb/tb_cache_controller.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module  : cache_pkg
// Brief   : Shared constants and FSM encoding for the data-cache controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int C_NUM_SETS    = 64;
  localparam int C_TAG_W       = 9;
  localparam int C_BASE_ADDR   = 1024;
  localparam int C_WORD_W      = 32;
  localparam int C_LINE_W      = 64;
  localparam int C_SRAM_ADDR_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_MISS  = 2'd1,
    ST_WRITE_THRU = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_controller_if.sv
// ============================================================================
// Module  : cache_controller_if
// Brief   : Memory-stage request bus plus SRAM-controller bus of the cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cache_controller_if;
  import cache_pkg::*;

  logic [C_WORD_W-1:0]      address;
  logic [C_WORD_W-1:0]      wdata;
  logic                     mem_read;
  logic                     mem_write;
  logic [C_WORD_W-1:0]      rdata;
  logic                     ready;
  logic [C_SRAM_ADDR_W-1:0] sram_address;
  logic [C_WORD_W-1:0]      sram_wdata;
  logic                     sram_read;
  logic                     sram_write;
  logic [C_LINE_W-1:0]      sram_rdata;
  logic                     sram_ready;

  // Requester / SRAM-model side
  modport master (
    output address, wdata, mem_read, mem_write, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

  // Cache controller side
  modport slave (
    input  address, wdata, mem_read, mem_write, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

endinterface

`default_nettype wire

// File: rtl/cache_way_array.sv
// ============================================================================
// Module  : cache_way_array
// Brief   : One cache way: valid/tag/data storage, tag compare, fill and word write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_way_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS = C_NUM_SETS,
  parameter int TAG_W    = C_TAG_W,
  localparam int IDX_W   = $clog2(NUM_SETS)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [IDX_W-1:0]    i_index,
  input  wire logic [TAG_W-1:0]    i_tag,
  input  wire logic                i_word_sel,
  input  wire logic                i_fill_en,
  input  wire logic [C_LINE_W-1:0] i_fill_data,
  input  wire logic                i_wr_en,
  input  wire logic [C_WORD_W-1:0] i_wr_data,
  output logic                     o_hit,
  output logic [C_WORD_W-1:0]      o_rdata
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [C_LINE_W-1:0] r_data [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Payload storage needs no reset: it is only trusted behind r_valid.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_index]  <= i_tag;
      r_data[i_index] <= i_fill_data;
    end else if (i_wr_en) begin
      if (i_word_sel) begin
        r_data[i_index][63:32] <= i_wr_data;
      end else begin
        r_data[i_index][31:0]  <= i_wr_data;
      end
    end
  end

  assign o_hit   = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_rdata = i_word_sel ? r_data[i_index][63:32] : r_data[i_index][31:0];

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// Module  : cache_controller
// Brief   : 2-way set-associative, write-through/no-allocate data cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_SETS  = C_NUM_SETS,
  parameter int TAG_W     = C_TAG_W,
  parameter int BASE_ADDR = C_BASE_ADDR,
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input wire logic          clk,
  input wire logic          rst,
  cache_controller_if.slave bus
);

  state_t              r_state;
  logic                r_sram_read;
  logic                r_sram_write;
  logic [NUM_SETS-1:0] r_lru;

  logic [C_WORD_W-1:0] w_eff;
  logic [IDX_W-1:0]    w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_word_sel;
  logic                w_victim;
  logic                w_any_hit;
  logic                w_read_req;
  logic [1:0]          w_hit;
  logic [1:0]          w_fill_en;
  logic [1:0]          w_wr_en;
  logic [C_WORD_W-1:0] w_way_rdata [2];
  logic [C_WORD_W-1:0] w_hit_rdata;
  logic                w_ready;
  logic [C_WORD_W-1:0] w_rdata;
  logic                w_unused;

  assign w_eff      = bus.address - 32'(BASE_ADDR);
  assign w_word_sel = w_eff[2];
  assign w_index    = w_eff[3 +: IDX_W];
  assign w_tag      = w_eff[3 + IDX_W +: TAG_W];
  assign w_unused   = ^{w_eff[31:C_SRAM_ADDR_W], w_eff[1:0]};

  // r_lru set means way 1 is least recent; reset value makes empty sets fill way 0 first.
  assign w_victim    = r_lru[w_index];
  assign w_any_hit   = |w_hit;
  assign w_hit_rdata = w_hit[1] ? w_way_rdata[1] : w_way_rdata[0];
  assign w_read_req  = bus.mem_read && !bus.mem_write;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_way
      assign w_fill_en[g] = (r_state == ST_READ_MISS) && bus.sram_ready && (w_victim == 1'(g));
      assign w_wr_en[g]   = (r_state == ST_WRITE_THRU) && bus.sram_ready && w_hit[g];

      cache_way_array #(
        .NUM_SETS (NUM_SETS),
        .TAG_W    (TAG_W)
      ) u_way (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_tag       (w_tag),
        .i_word_sel  (w_word_sel),
        .i_fill_en   (w_fill_en[g]),
        .i_fill_data (bus.sram_rdata),
        .i_wr_en     (w_wr_en[g]),
        .i_wr_data   (bus.wdata),
        .o_hit       (w_hit[g]),
        .o_rdata     (w_way_rdata[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sram_read  <= 1'b0;
      r_sram_write <= 1'b0;
      r_lru        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_write) begin
            r_state      <= ST_WRITE_THRU;
            r_sram_write <= 1'b1;
          end else if (w_read_req) begin
            if (w_any_hit) begin
              r_lru[w_index] <= w_hit[0];
            end else begin
              r_state     <= ST_READ_MISS;
              r_sram_read <= 1'b1;
            end
          end
        end
        ST_READ_MISS: begin
          if (bus.sram_ready) begin
            r_lru[w_index] <= ~w_victim;
            r_state        <= ST_IDLE;
            r_sram_read    <= 1'b0;
          end
        end
        ST_WRITE_THRU: begin
          if (bus.sram_ready) begin
            if (w_any_hit) begin
              r_lru[w_index] <= w_hit[0];
            end
            r_state      <= ST_IDLE;
            r_sram_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_sram_read  <= 1'b0;
          r_sram_write <= 1'b0;
        end
      endcase
    end
  end

  // Hits and SRAM completions both answer in the same cycle they are seen.
  always_comb begin
    w_ready = 1'b1;
    w_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_write) begin
          w_ready = 1'b0;
        end else if (w_read_req) begin
          if (w_any_hit) begin
            w_rdata = w_hit_rdata;
          end else begin
            w_ready = 1'b0;
          end
        end
      end
      ST_READ_MISS: begin
        w_ready = bus.sram_ready;
        if (bus.sram_ready) begin
          w_rdata = w_word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
        end
      end
      ST_WRITE_THRU: begin
        w_ready = bus.sram_ready;
      end
      default: begin
        w_ready = 1'b1;
      end
    endcase
  end

  assign bus.ready        = w_ready;
  assign bus.rdata        = w_rdata;
  assign bus.sram_read    = r_sram_read;
  assign bus.sram_write   = r_sram_write;
  assign bus.sram_wdata   = bus.wdata;
  assign bus.sram_address = (r_state == ST_READ_MISS) ?
                            {w_eff[C_SRAM_ADDR_W-1:3], 3'b000} : w_eff[C_SRAM_ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// Module  : tb_cache_controller
// Brief   : Directed self-checking bench for the 2-way data cache controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_controller;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_controller_if bus ();

  cache_controller #(
    .NUM_SETS  (64),
    .TAG_W     (9),
    .BASE_ADDR (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.address  = addr;
    bus.mem_read = 1'b1;
    #1;
    chk({tag, ".ready"}, 64'(bus.ready), 64'd1);
    chk({tag, ".rdata"}, 64'(bus.rdata), 64'(exp));
    chk({tag, ".sram_read"}, 64'(bus.sram_read), 64'd0);
    step();
    bus.mem_read = 1'b0;
    #1;
    chk({tag, ".sram_read_after"}, 64'(bus.sram_read), 64'd0);
  endtask

  task automatic load_miss(input string tag, input logic [31:0] addr, input logic [17:0] saddr,
                           input logic [63:0] line, input logic [31:0] exp);
    bus.address  = addr;
    bus.mem_read = 1'b1;
    #1;
    chk({tag, ".ready_req"}, 64'(bus.ready), 64'd0);
    step();
    chk({tag, ".sram_read"}, 64'(bus.sram_read), 64'd1);
    chk({tag, ".sram_write"}, 64'(bus.sram_write), 64'd0);
    chk({tag, ".sram_address"}, 64'(bus.sram_address), 64'(saddr));
    chk({tag, ".ready_wait"}, 64'(bus.ready), 64'd0);
    bus.sram_rdata = line;
    bus.sram_ready = 1'b1;
    #1;
    chk({tag, ".ready_done"}, 64'(bus.ready), 64'd1);
    chk({tag, ".rdata"}, 64'(bus.rdata), 64'(exp));
    step();
    bus.sram_ready = 1'b0;
    bus.mem_read   = 1'b0;
    #1;
    chk({tag, ".sram_read_idle"}, 64'(bus.sram_read), 64'd0);
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [17:0] saddr, input logic also_read);
    bus.address   = addr;
    bus.wdata     = data;
    bus.mem_write = 1'b1;
    bus.mem_read  = also_read;
    #1;
    chk({tag, ".ready_req"}, 64'(bus.ready), 64'd0);
    step();
    chk({tag, ".sram_write"}, 64'(bus.sram_write), 64'd1);
    chk({tag, ".sram_read"}, 64'(bus.sram_read), 64'd0);
    chk({tag, ".sram_address"}, 64'(bus.sram_address), 64'(saddr));
    chk({tag, ".sram_wdata"}, 64'(bus.sram_wdata), 64'(data));
    chk({tag, ".ready_wait"}, 64'(bus.ready), 64'd0);
    bus.sram_ready = 1'b1;
    #1;
    chk({tag, ".ready_done"}, 64'(bus.ready), 64'd1);
    step();
    bus.sram_ready = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    #1;
    chk({tag, ".sram_write_idle"}, 64'(bus.sram_write), 64'd0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.address    = '0;
    bus.wdata      = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.sram_rdata = '0;
    bus.sram_ready = 1'b0;
    step();
    step();
    chk("reset.ready", 64'(bus.ready), 64'd1);
    chk("reset.rdata", 64'(bus.rdata), 64'd0);
    chk("reset.sram_read", 64'(bus.sram_read), 64'd0);
    chk("reset.sram_write", 64'(bus.sram_write), 64'd0);
    rst = 1'b0;
    step();
    chk("idle.ready", 64'(bus.ready), 64'd1);

    // First miss, then a hit on the other word of the same line
    load_miss("ld400", 32'h400, 18'h0, 64'h0000000B_0000000A, 32'hA);
    load_hit ("ld404", 32'h404, 32'hB);

    // Three tags in set 0: the third fill evicts the line holding 0x400
    load_miss("ld600", 32'h600, 18'h200, 64'h0000000D_0000000C, 32'hC);
    load_miss("ld800", 32'h800, 18'h400, 64'h0000000F_0000000E, 32'hE);
    load_miss("re400", 32'h400, 18'h0, 64'h0000000B_0000000A, 32'hA);
    load_miss("ld604", 32'h604, 18'h200, 64'h0000000D_0000000C, 32'hD);

    // Write-through hit updates only the addressed word
    store   ("st404", 32'h404, 32'h12345678, 18'h4, 1'b0);
    load_hit("hit404", 32'h404, 32'h12345678);
    load_hit("hit400", 32'h400, 32'hA);

    // No write-allocate; read+write together behaves as a write
    store    ("st1000", 32'h1000, 32'hCAFEF00D, 18'hC00, 1'b0);
    store    ("rw1004", 32'h1004, 32'h55AA55AA, 18'hC04, 1'b1);
    load_miss("ld1000", 32'h1000, 18'hC00, 64'h00000002_CAFEF00D, 32'hCAFEF00D);

    // Reset in the middle of a miss aborts it with no fill
    bus.address  = 32'h808;
    bus.mem_read = 1'b1;
    step();
    chk("abort.sram_read_before", 64'(bus.sram_read), 64'd1);
    bus.sram_rdata = 64'h11111111_22222222;
    bus.sram_ready = 1'b1;
    rst            = 1'b1;
    #1;
    chk("abort.sram_read", 64'(bus.sram_read), 64'd0);
    chk("abort.sram_write", 64'(bus.sram_write), 64'd0);
    bus.mem_read   = 1'b0;
    bus.sram_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    load_miss("post808", 32'h808, 18'h408, 64'h00000077_00000066, 32'h66);
    load_miss("post400", 32'h400, 18'h0, 64'h0000000B_0000000A, 32'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
